inference_sequencer: RTL and testbench



---
 rtl/tm_seq_pkg.sv | 37 +++
 rtl/addr_sweep.sv | 37 +++
 rtl/inference_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_inference_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_seq_pkg.sv
// Shared types and field layout for the Tsetlin inference sequencer.
// The same layout is used for model_params, cfg_out and the sticky error vector.
package tm_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_CL,
        S_LOAD_WT,
        S_WAIT_IMG,
        S_RECV,
        S_ARM,
        S_COMPUTE,
        S_RESULT,
        S_DRAIN
    } state_t;

    localparam int CFG_W           = 19;
    localparam int CFG_PATCH_LSB   = 0;
    localparam int CFG_STRIDE_LSB  = 3;
    localparam int CFG_CLAUSES_LSB = 6;
    localparam int CFG_CLAUSES_W   = 9;
    localparam int CFG_CLASSES_LSB = 15;
    localparam int CFG_CLASSES_W   = 4;

    localparam int ERR_CFG   = 0;
    localparam int ERR_FRAME = 1;
    localparam int ERR_TMO   = 2;

    function automatic logic [CFG_CLAUSES_W-1:0] cfg_clauses(input logic [CFG_W-1:0] p);
        return p[CFG_CLAUSES_LSB +: CFG_CLAUSES_W];
    endfunction

    function automatic logic [CFG_CLASSES_W-1:0] cfg_classes(input logic [CFG_W-1:0] p);
        return p[CFG_CLASSES_LSB +: CFG_CLASSES_W];
    endfunction

endpackage

// File: rtl/addr_sweep.sv
// Address counter for BRAM load sweeps: counts 0..limit-1 while enabled and
// wraps to 0 on the last address so the next range starts without a restart.
module addr_sweep #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] addr,
    output logic         last
);

    logic [W-1:0] cnt_q, cnt_d;

    assign addr = cnt_q;
    assign last = (cnt_q == limit - W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/inference_sequencer.sv
// Top-level sequencer: loads clause/weight BRAM address ranges, receives
// 8-beat image frames, arms the core and returns one class result per image.
module inference_sequencer
    import tm_seq_pkg::*;
#(
    parameter int CLAUSE_MAX = 140,
    parameter int CLASS_MAX  = 10,
    parameter int WROWS      = 5,
    parameter int BEATS      = 8,
    parameter int TMO_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CFG_W-1:0]  model_params,
    output logic [CFG_W-1:0]  cfg_out,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic [15:0]       s_tkeep,
    output logic              beat_we,
    output logic [2:0]        beat_idx,
    output logic [31:0]       clause_addr,
    output logic              clause_we,
    output logic [31:0]       weight_addr,
    output logic              weight_we,
    output logic              core_img_rst,
    input  logic              core_done,
    input  logic [3:0]        core_class,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3:0]        m_class,
    output logic              m_err,
    output logic              busy,
    output logic [2:0]        err,
    output logic [15:0]       img_count
);

    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    state_t                     state_q, state_d;
    logic [CFG_W-1:0]           cfg_q, cfg_d;
    logic [2:0]                 err_q, err_d;
    logic [2:0]                 beat_cnt_q, beat_cnt_d;
    logic                       frame_bad_q, frame_bad_d;
    logic                       beat_we_q, beat_we_d;
    logic [2:0]                 beat_idx_q, beat_idx_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic [3:0]                 m_class_q, m_class_d;
    logic                       m_err_q, m_err_d;
    logic [15:0]                img_cnt_q, img_cnt_d;

    logic                       tready_c;
    logic [2:0]                 cur_idx;
    logic                       bad_now;
    logic                       keep_bad;
    logic                       cfg_invalid;

    logic [CFG_CLAUSES_W-1:0]   sweep_limit, sweep_addr;
    logic                       sweep_last, sweep_en;
    logic [6:0]                 wt_rows;

    // Weight row count is deliberately formed at 7 bits (max 15*5 fits).
    assign wt_rows     = 7'(cfg_classes(cfg_q)) * 7'(WROWS);
    assign sweep_limit = (state_q == S_LOAD_WT) ? {2'b00, wt_rows} : cfg_clauses(cfg_q);
    assign sweep_en    = (state_q == S_LOAD_CL) || (state_q == S_LOAD_WT);

    addr_sweep #(.W(CFG_CLAUSES_W)) u_sweep (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == S_IDLE),
        .en    (sweep_en),
        .limit (sweep_limit),
        .addr  (sweep_addr),
        .last  (sweep_last)
    );

    assign keep_bad    = (s_tkeep != 16'hFFFF);
    assign cfg_invalid = (cfg_clauses(model_params) == '0)
                      || (cfg_clauses(model_params) > 9'(CLAUSE_MAX))
                      || (cfg_classes(model_params) == '0)
                      || (cfg_classes(model_params) > 4'(CLASS_MAX));

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        err_d       = err_q;
        beat_cnt_d  = beat_cnt_q;
        frame_bad_d = frame_bad_q;
        beat_we_d   = 1'b0;
        beat_idx_d  = beat_idx_q;
        tmo_d       = tmo_q;
        m_class_d   = m_class_q;
        m_err_d     = m_err_q;
        img_cnt_d   = img_cnt_q;
        tready_c    = 1'b0;
        cur_idx     = (state_q == S_RECV) ? beat_cnt_q : 3'd0;
        bad_now     = keep_bad || ((state_q == S_RECV) && frame_bad_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d = model_params;
                    err_d = '0;
                    if (cfg_invalid) err_d[ERR_CFG] = 1'b1;
                    else             state_d = S_LOAD_CL;
                end
            end
            S_LOAD_CL: if (sweep_last) state_d = S_LOAD_WT;
            S_LOAD_WT: if (sweep_last) state_d = S_WAIT_IMG;
            S_WAIT_IMG, S_RECV: begin
                tready_c = 1'b1;
                if (s_tvalid) begin
                    beat_we_d  = 1'b1;
                    beat_idx_d = cur_idx;
                    if (keep_bad) err_d[ERR_FRAME] = 1'b1;
                    // A frame is kept only if it ends on tlast at the last beat with clean keeps.
                    if (s_tlast) begin
                        if ((cur_idx == LAST_BEAT) && !bad_now) begin
                            state_d = S_ARM;
                        end else begin
                            err_d[ERR_FRAME] = 1'b1;
                            state_d          = S_WAIT_IMG;
                        end
                    end else if (cur_idx == LAST_BEAT) begin
                        err_d[ERR_FRAME] = 1'b1;
                        state_d          = S_DRAIN;
                    end else begin
                        state_d     = S_RECV;
                        beat_cnt_d  = cur_idx + 3'd1;
                        frame_bad_d = bad_now;
                    end
                end
            end
            S_DRAIN: begin
                tready_c = 1'b1;
                if (s_tvalid && s_tlast) state_d = S_WAIT_IMG;
            end
            S_ARM: begin
                tmo_d   = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (core_done) begin
                    m_class_d = core_class;
                    m_err_d   = 1'b0;
                    state_d   = S_RESULT;
                end else if (tmo_d == '1) begin
                    err_d[ERR_TMO] = 1'b1;
                    m_class_d      = 4'hF;
                    m_err_d        = 1'b1;
                    state_d        = S_RESULT;
                end
            end
            S_RESULT: begin
                if (m_ready) begin
                    img_cnt_d = img_cnt_q + 16'd1;
                    state_d   = S_WAIT_IMG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            err_q       <= '0;
            beat_cnt_q  <= '0;
            frame_bad_q <= 1'b0;
            beat_we_q   <= 1'b0;
            beat_idx_q  <= '0;
            tmo_q       <= '0;
            m_class_q   <= '0;
            m_err_q     <= 1'b0;
            img_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_bad_q <= frame_bad_d;
            beat_we_q   <= beat_we_d;
            beat_idx_q  <= beat_idx_d;
            tmo_q       <= tmo_d;
            m_class_q   <= m_class_d;
            m_err_q     <= m_err_d;
            img_cnt_q   <= img_cnt_d;
        end
    end

    assign cfg_out      = cfg_q;
    assign s_tready     = tready_c;
    assign beat_we      = beat_we_q;
    assign beat_idx     = beat_idx_q;
    assign clause_we    = (state_q == S_LOAD_CL);
    assign clause_addr  = clause_we ? 32'(sweep_addr) : 32'd0;
    assign weight_we    = (state_q == S_LOAD_WT);
    assign weight_addr  = weight_we ? 32'(sweep_addr) : 32'd0;
    assign core_img_rst = (state_q == S_ARM);
    assign m_valid      = (state_q == S_RESULT);
    assign m_class      = m_class_q;
    assign m_err        = m_err_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;
    assign img_count    = img_cnt_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed plus randomized bench for inference_sequencer with a frame/result
// reference model; uses a short timeout counter to keep runs brief.
module tb_inference_sequencer;

    localparam int TMO_W = 8;
    localparam int WROWS = 5;

    logic        clk = 1'b0;
    logic        rst, start, s_tvalid, s_tlast, core_done, m_ready;
    logic [18:0] model_params;
    logic [15:0] s_tkeep;
    logic [3:0]  core_class;
    logic [18:0] cfg_out;
    logic        s_tready, beat_we, clause_we, weight_we, core_img_rst;
    logic        m_valid, m_err, busy;
    logic [2:0]  beat_idx, err;
    logic [31:0] clause_addr, weight_addr;
    logic [3:0]  m_class;
    logic [15:0] img_count;

    inference_sequencer #(.TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .start(start), .model_params(model_params),
        .cfg_out(cfg_out), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tkeep(s_tkeep), .beat_we(beat_we),
        .beat_idx(beat_idx), .clause_addr(clause_addr), .clause_we(clause_we),
        .weight_addr(weight_addr), .weight_we(weight_we),
        .core_img_rst(core_img_rst), .core_done(core_done),
        .core_class(core_class), .m_valid(m_valid), .m_ready(m_ready),
        .m_class(m_class), .m_err(m_err), .busy(busy), .err(err),
        .img_count(img_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int clause_q[$];
    int weight_q[$];
    int beat_q[$];
    int img_rst_cnt = 0;
    int hs_cnt = 0;
    int exp_img = 0;
    logic [2:0] exp_err = 3'b000;

    always @(negedge clk) begin
        if (clause_we) clause_q.push_back(int'(clause_addr));
        if (weight_we) weight_q.push_back(int'(weight_addr));
        if (beat_we) beat_q.push_back(int'(beat_idx));
        if (core_img_rst) img_rst_cnt++;
        if (m_valid && m_ready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sequences are always 0,1,..,n-1.
    task automatic chk_seq(input string tag, input int q[$], input int n);
        int mis;
        mis = 0;
        for (int i = 0; i < q.size(); i++) if (i >= n || q[i] != i) mis++;
        chk({tag, "_len"}, q.size(), n);
        chk({tag, "_vals"}, mis, 0);
    endtask

    function automatic logic [18:0] mk(input int cl, input int cs);
        logic [18:0] p;
        p = 19'($urandom);
        p[14:6] = 9'(cl);
        p[18:15] = 4'(cs);
        return p;
    endfunction

    task automatic clear_mon();
        clause_q.delete();
        weight_q.delete();
        beat_q.delete();
        img_rst_cnt = 0;
    endtask

    task automatic do_start(input logic [18:0] p);
        model_params = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic last, input logic [15:0] keep);
        int n;
        s_tvalid = 1'b1;
        s_tlast  = last;
        s_tkeep  = keep;
        n = 0;
        while (!s_tready && n < 100) begin tick(); n++; end
        if (n >= 100) chk("tready_wait_expired", 0, 1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = 16'hFFFF;
    endtask

    task automatic send_frame(input int len, input int badpos, input int gap_max);
        logic [15:0] kv;
        for (int b = 0; b < len; b++) begin
            for (int g = $urandom_range(gap_max, 0); g > 0; g--) tick();
            kv = 16'hFFFF;
            if (b == badpos) begin
                kv = 16'($urandom);
                if (kv == 16'hFFFF) kv = 16'h0000;
            end
            send_beat(b == len - 1, kv);
        end
    endtask

    // Called in the cycle core_img_rst is high.
    task automatic finish_image(input int delay, input logic [3:0] cls, input int hold);
        int ok, hs0;
        ok = 1;
        for (int i = 0; i < delay; i++) begin
            if (s_tready !== 1'b0 || m_valid !== 1'b0) ok = 0;
            tick();
        end
        chk("compute_quiet", ok, 1);
        core_done  = 1'b1;
        core_class = cls;
        tick();
        core_done  = 1'b0;
        core_class = 4'($urandom);
        chk("res_valid", m_valid, 1);
        chk("res_class", m_class, cls);
        chk("res_err", m_err, 0);
        ok = 1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (m_valid !== 1'b1 || m_class !== cls || s_tready !== 1'b0) ok = 0;
        end
        if (hold > 0) chk("res_hold_stable", ok, 1);
        hs0 = hs_cnt;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        exp_img++;
        chk("handshakes", hs_cnt - hs0, 1);
        chk("img_count", img_count, 32'(exp_img & 16'hFFFF));
        chk("post_valid", m_valid, 0);
        chk("post_tready", s_tready, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_flags"}, {busy, s_tready, beat_we, clause_we, weight_we,
                              core_img_rst, m_valid, m_err}, 0);
        chk({tag, "_cfg"}, cfg_out, 0);
        chk({tag, "_class"}, m_class, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_imgcnt"}, img_count, 0);
        chk({tag, "_addrs"}, clause_addr | weight_addr | 32'(beat_idx), 0);
    endtask

    initial begin
        logic [18:0] p;
        int n, len, badpos;
        logic good;

        rst = 1'b1; start = 1'b0; model_params = '0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 16'hFFFF;
        core_done = 1'b0; core_class = '0; m_ready = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Illegal configurations stay in IDLE with err[0].
        clear_mon();
        p = mk(100, 0);
        do_start(p);
        chk("cfg0_err", err, 3'b001);
        chk("cfg0_busy", busy, 0);
        chk("cfg0_latched", cfg_out, p);
        p = mk(141, 3);
        do_start(p);
        chk("cfg141_err", err, 3'b001);
        p = mk(5, 11);
        do_start(p);
        chk("cfg11_err", err, 3'b001);
        repeat (4) tick();
        chk("cfg_no_writes", clause_q.size() + weight_q.size(), 0);
        chk("cfg_idle", busy, 0);

        // Full-size load sweep.
        clear_mon();
        p = mk(140, 10);
        do_start(p);
        exp_err = 3'b000;
        chk("load_err_cleared", err, 0);
        chk("load_first_we", clause_we, 1);
        n = 0;
        while (!s_tready && n < 1000) begin tick(); n++; end
        chk("load_cycles", n, 140 + 10 * WROWS);
        chk_seq("clause", clause_q, 140);
        chk_seq("weight", weight_q, 10 * WROWS);
        chk("load_cfg", cfg_out, p);

        // Start outside IDLE is ignored.
        clear_mon();
        do_start(mk(5, 1));
        repeat (3) tick();
        chk("start_ignored_writes", clause_q.size(), 0);
        chk("start_ignored_cfg", cfg_out, p);
        chk("start_ignored_tready", s_tready, 1);

        // Happy path frame.
        clear_mon();
        send_frame(8, -1, 0);
        chk("happy_img_rst", core_img_rst, 1);
        finish_image(50, 4'd7, 0);
        chk_seq("happy_beat", beat_q, 8);
        chk("happy_img_rst_cnt", img_rst_cnt, 1);

        // Mixed directed and random frames against the frame model.
        for (int it = 0; it < 14; it++) begin
            clear_mon();
            badpos = -1;
            case (it)
                0: len = 4;
                1: len = 8;
                2: len = 11;
                default: begin
                    case ($urandom_range(3, 0))
                        0: len = 8;
                        1: len = $urandom_range(7, 1);
                        2: len = $urandom_range(11, 9);
                        default: begin len = 8; badpos = $urandom_range(7, 0); end
                    endcase
                end
            endcase
            good = (len == 8) && (badpos < 0);
            if (!good) exp_err[1] = 1'b1;
            send_frame(len, badpos, 2);
            if (good) begin
                chk("frame_img_rst", core_img_rst, 1);
                finish_image($urandom_range(20, 1), 4'($urandom_range(9, 0)), $urandom_range(3, 0));
            end else begin
                tick(); tick();
                chk("bad_no_img_rst", img_rst_cnt, 0);
                chk("bad_wait_img", s_tready, 1);
                chk("bad_no_result", m_valid, 0);
            end
            chk_seq("frame_beat", beat_q, (len < 8) ? len : 8);
            chk("frame_err", err, exp_err);
        end

        // Timeout: no core_done.
        clear_mon();
        send_frame(8, -1, 0);
        chk("tmo_img_rst", core_img_rst, 1);
        n = 0;
        while (!m_valid && n < 1000) begin tick(); n++; end
        chk("tmo_cycles", n, 2 ** TMO_W);
        chk("tmo_class", m_class, 4'hF);
        chk("tmo_merr", m_err, 1);
        exp_err[2] = 1'b1;
        chk("tmo_err", err, exp_err);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        exp_img++;
        chk("tmo_img_count", img_count, 32'(exp_img & 16'hFFFF));

        // core_done outside COMPUTE has no effect.
        core_done = 1'b1; core_class = 4'd3;
        tick();
        core_done = 1'b0;
        tick();
        chk("stray_done_valid", m_valid, 0);
        chk("stray_done_tready", s_tready, 1);

        // Result backpressure.
        clear_mon();
        send_frame(8, -1, 1);
        finish_image(5, 4'd3, 20);

        // Reset during beat 4 of a frame.
        for (int b = 0; b < 4; b++) send_beat(1'b0, 16'hFFFF);
        s_tvalid = 1'b1;
        rst = 1'b1;
        tick();
        s_tvalid = 1'b0;
        check_reset("midframe_rst");
        rst = 1'b0;
        tick();
        chk("post_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
